calc_sequencer: RTL

Controller that sequences the board-level 4-bit calculator datapath. It debounces the two push-buttons and walks the user through operand A, operator, and operand B entry. It then triggers one add/subtract/multiply execution and holds the result for the display decoders. It sits between the raw DE10-Lite I/O (KEY, SW) and the bcd_decoder instances, replacing ad-hoc button handling in the top level.

---
 rtl/calc_pkg.sv | 30 +++
 rtl/calc_sequencer_if.sv | 25 ++
 rtl/key_debounce.sv | 48 ++++
 rtl/calc_sequencer.sv | 128 ++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the 4-bit calculator sequencer.
package calc_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 1_000_000;
  localparam int unsigned OPND_W           = 4;
  localparam int unsigned OP_W             = 2;
  localparam int unsigned RES_W            = 8;
  localparam int unsigned STATE_W          = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    GET_OP = 3'd1,
    GET_B  = 3'd2,
    EXEC   = 3'd3,
    SHOW   = 3'd4
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_MUL = 2'b10;
  localparam logic [OP_W-1:0] OP_RSV = 2'b11;

  // Latched outcome of one execution, as presented to the display path
  typedef struct packed {
    logic [RES_W-1:0] mag;
    logic             neg;
    logic             err;
  } calc_res_t;

endpackage

// File: rtl/calc_sequencer_if.sv
// Board-side bundle: raw buttons/switches in, captured operands and result out.
interface calc_sequencer_if;
  import calc_pkg::*;

  logic [1:0]         KEY;
  logic [9:0]         SW;
  logic [OPND_W-1:0]  a_o;
  logic [OPND_W-1:0]  b_o;
  logic [RES_W-1:0]   result;
  logic               neg;
  logic               err;
  logic               result_valid;
  logic [STATE_W-1:0] state_o;

  modport master (
    output KEY, SW,
    input  a_o, b_o, result, neg, err, result_valid, state_o
  );

  modport slave (
    input  KEY, SW,
    output a_o, b_o, result, neg, err, result_valid, state_o
  );

endinterface

// File: rtl/key_debounce.sv
// Active-low button: 2-FF synchronizer, stability counter, one-cycle press pulse.
module key_debounce
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic MAX10_CLK1_50,
  input  logic rst,
  input  logic key_n,
  output logic press_p
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronizer resets to the released (high) level
  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], key_n};
  end

  assign level = ~sync_q[1];

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_p  <= 1'b0;
    end else if (level == stable_q) begin
      cnt_q    <= '0;
      press_p  <= 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      stable_q <= level;
      cnt_q    <= '0;
      press_p  <= level;
    end else begin
      cnt_q    <= cnt_q + CNT_W'(1);
      press_p  <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Button-driven sequencer: capture A, op, B, execute once, hold result for display.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic MAX10_CLK1_50,
  input  logic rst,
  calc_sequencer_if.slave io
);

  logic              enter_p;
  logic              clear_p;
  state_t            state_q, state_d;
  logic [OPND_W-1:0] a_q, a_d;
  logic [OPND_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  calc_res_t         res_q, res_d;
  logic              valid_q, valid_d;
  logic              unused_sw_bits;

  assign unused_sw_bits = ^io.SW[7:4];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .MAX10_CLK1_50 (MAX10_CLK1_50),
    .rst           (rst),
    .key_n         (io.KEY[0]),
    .press_p       (enter_p)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .MAX10_CLK1_50 (MAX10_CLK1_50),
    .rst           (rst),
    .key_n         (io.KEY[1]),
    .press_p       (clear_p)
  );

  function automatic calc_res_t calc_eval(input logic [OP_W-1:0] op,
                                          input logic [OPND_W-1:0] a,
                                          input logic [OPND_W-1:0] b);
    calc_res_t r;
    r = '0;
    case (op)
      OP_ADD: r.mag = RES_W'(a) + RES_W'(b);
      OP_SUB: begin
        if (a >= b) begin
          r.mag = RES_W'(a - b);
        end else begin
          r.mag = RES_W'(b - a);
          r.neg = 1'b1;
        end
      end
      OP_MUL: r.mag = RES_W'(a) * RES_W'(b);
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  // Clear has priority over enter; any path into IDLE wipes the captured data
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    valid_d = 1'b0;

    if (clear_p) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (enter_p) begin
          a_d     = io.SW[3:0];
          state_d = GET_OP;
        end
        GET_OP: if (enter_p) begin
          op_d    = io.SW[9:8];
          state_d = GET_B;
        end
        GET_B: if (enter_p) begin
          b_d     = io.SW[3:0];
          state_d = EXEC;
        end
        EXEC: begin
          res_d   = calc_eval(op_q, a_q, b_q);
          state_d = SHOW;
        end
        SHOW: if (enter_p) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (state_d == IDLE) begin
      a_d   = '0;
      b_d   = '0;
      op_d  = '0;
      res_d = '0;
    end
    valid_d = (state_d == SHOW);
  end

  assign io.a_o          = a_q;
  assign io.b_o          = b_q;
  assign io.result       = res_q.mag;
  assign io.neg          = res_q.neg;
  assign io.err          = res_q.err;
  assign io.result_valid = valid_q;
  assign io.state_o      = state_q;

endmodule
